// File: rtl/dna_pkg.sv
// ----------------------------------------------------------------------------
// dna_pkg : base codes, ASCII constants, encoder FSM states, char classifier
// Build option: DNA_ENC_LOWERCASE_EN.                           Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dna_pkg;

  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;
  localparam logic [1:0] BASE_G = 2'b10;
  localparam logic [1:0] BASE_T = 2'b11;

  localparam logic [7:0] CH_A    = 8'h41;
  localparam logic [7:0] CH_C    = 8'h43;
  localparam logic [7:0] CH_G    = 8'h47;
  localparam logic [7:0] CH_T    = 8'h54;
  localparam logic [7:0] CH_N    = 8'h4E;
  localparam logic [7:0] CH_N_LC = 8'h6E;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_CR   = 8'h0D;
`ifdef DNA_ENC_LOWERCASE_EN
  localparam logic [7:0] CH_A_LC = 8'h61;
  localparam logic [7:0] CH_C_LC = 8'h63;
  localparam logic [7:0] CH_G_LC = 8'h67;
  localparam logic [7:0] CH_T_LC = 8'h74;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } enc_state_e;

  typedef struct packed {
    logic       is_base;
    logic       is_skip;
    logic [1:0] code;
  } char_class_t;

  // Neither flag set means the character is illegal.
  function automatic char_class_t classify(input logic [7:0] ch);
    char_class_t cls;
    cls = '0;
    case (ch)
      CH_A:    begin cls.is_base = 1'b1; cls.code = BASE_A; end
      CH_C:    begin cls.is_base = 1'b1; cls.code = BASE_C; end
      CH_G:    begin cls.is_base = 1'b1; cls.code = BASE_G; end
      CH_T:    begin cls.is_base = 1'b1; cls.code = BASE_T; end
`ifdef DNA_ENC_LOWERCASE_EN
      CH_A_LC: begin cls.is_base = 1'b1; cls.code = BASE_A; end
      CH_C_LC: begin cls.is_base = 1'b1; cls.code = BASE_C; end
      CH_G_LC: begin cls.is_base = 1'b1; cls.code = BASE_G; end
      CH_T_LC: begin cls.is_base = 1'b1; cls.code = BASE_T; end
`endif
      CH_N, CH_N_LC, CH_LF, CH_CR: cls.is_skip = 1'b1;
      default: ;
    endcase
    return cls;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dna_base_encoder_if.sv
// ----------------------------------------------------------------------------
// dna_base_encoder_if : character stream in, base stream out, record status
//                                                               Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface dna_base_encoder_if #(
  parameter int COUNT_W = 16
);
  logic [7:0]         in_char;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [1:0]         dna_out;
  logic               dna_valid;
  logic               out_ready;
  logic               rec_end;
  logic [COUNT_W-1:0] base_count;
  logic               err_flag;

  modport master (
    output in_char, in_valid, in_last, out_ready,
    input  in_ready, dna_out, dna_valid, rec_end, base_count, err_flag
  );

  modport slave (
    input  in_char, in_valid, in_last, out_ready,
    output in_ready, dna_out, dna_valid, rec_end, base_count, err_flag
  );
endinterface

`default_nettype wire

// File: rtl/dna_sync_fifo.sv
// ----------------------------------------------------------------------------
// dna_sync_fifo : power-of-2 depth synchronous FIFO of 2-bit base codes
//                                                               Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dna_sync_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [1:0] push_data,
  input  logic       pop,
  output logic [1:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("dna_sync_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  // Pointers are exactly AW bits wide, so the increment wraps by itself.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dna_base_encoder.sv
// ----------------------------------------------------------------------------
// dna_base_encoder : ASCII nucleotide stream to 2-bit base codes with record
// count/error tracking. Build option: DNA_ENC_LOWERCASE_EN.     Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dna_base_encoder
  import dna_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  dna_base_encoder_if.slave  bus
);

  enc_state_e         state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               err_q, err_d;
  logic               rec_end_q, rec_end_d;

  char_class_t        cls;
  logic               accept;
  logic               push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [1:0]         fifo_head;
  logic [COUNT_W-1:0] count_base;
  logic               err_base;

  assign cls    = classify(bus.in_char);
  // Gated by rst_n so the upstream sees no ready while reset is asserted.
  assign bus.in_ready = rst_n & ((state_q == ST_ERR) | ~fifo_full);
  assign accept       = bus.in_valid & bus.in_ready;

  assign bus.dna_out    = fifo_head;
  assign bus.dna_valid  = ~fifo_empty;
  assign bus.rec_end    = rec_end_q;
  assign bus.base_count = count_q;
  assign bus.err_flag   = err_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    err_d      = err_q;
    rec_end_d  = 1'b0;
    push       = 1'b0;
    // The first beat of a record starts from a clean count and flag.
    count_base = (state_q == ST_IDLE) ? '0 : count_q;
    err_base   = (state_q == ST_IDLE) ? 1'b0 : err_q;

    if (accept) begin
      if (state_q != ST_ERR) begin
        count_d = count_base;
        err_d   = err_base;
        state_d = ST_RUN;
        if (cls.is_base) begin
          push = 1'b1;
          if (count_base != '1) begin
            count_d = count_base + COUNT_W'(1);
          end
        end else if (!cls.is_skip) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end
      end
      if (bus.in_last) begin
        rec_end_d = 1'b1;
        state_d   = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      err_q     <= 1'b0;
      rec_end_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      err_q     <= err_d;
      rec_end_q <= rec_end_d;
    end
  end

  dna_sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (cls.code),
    .pop       (bus.out_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

`default_nettype wire
